// File: rtl/serial_add_ctrl_if.sv
// Host-side handshake and operand/result bundle for the bit-serial adder controller.
// The host drives the master side; the controller implements the slave side.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell (two half adders plus an OR)
// walks LSB-first over two latched WIDTH-bit operands with a start/busy/done handshake.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    serial_add_ctrl_if.slave   bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             accept;
    logic             last_bit;
    logic             ha0_s, ha0_c, ha1_s, ha1_c, cell_c;
    logic [WIDTH-1:0] res_shifted;

    // Full-adder cell assembled from two half adders; carries never both set.
    assign ha0_s  = a_sh_q[0] ^ b_sh_q[0];
    assign ha0_c  = a_sh_q[0] & b_sh_q[0];
    assign ha1_s  = ha0_s ^ carry_q;
    assign ha1_c  = ha0_s & carry_q;
    assign cell_c = ha0_c | ha1_c;

    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_shifted = ha1_s;
        end else begin : g_res_wn
            assign res_shifted = {ha1_s, res_sh_q[WIDTH-1:1]};
        end
    endgenerate

    assign accept   = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign last_bit = (state_q == S_RUN) && (cnt_q == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (bus.start) state_d = S_RUN;
            S_RUN:   if (cnt_q == LAST) state_d = S_DONE;
            S_DONE:  state_d = bus.start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state_q == S_RUN);
        bus.done = (state_q == S_DONE);
        bus.sum  = sum_q;
        bus.cout = cout_q;
    end

    // Datapath next state: load on accepted start, shift one bit per RUN cycle.
    always_comb begin
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        if (accept) begin
            a_sh_d  = bus.a;
            b_sh_d  = bus.b;
            carry_d = bus.cin;
            cnt_d   = '0;
        end else if (state_q == S_RUN) begin
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            res_sh_d = res_shifted;
            carry_d  = cell_c;
            cnt_d    = cnt_q + CW'(1);
            if (last_bit) begin
                sum_d  = res_shifted;
                cout_d = cell_c;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: an 8-bit and a 1-bit instance on a shared clock/reset.
module tb_serial_add_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    serial_add_ctrl_if #(.WIDTH(8)) if8 ();
    serial_add_ctrl_if #(.WIDTH(1)) if1 ();

    serial_add_ctrl #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8.slave));
    serial_add_ctrl #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0;
        if1.start = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0;
        rst = 1'b1;
        tick(2);
        checks++;
        if ({if8.busy, if8.done, if8.sum, if8.cout} !== 11'h0) begin
            errors++;
            $display("FAIL reset8 busy=%b done=%b sum=%h cout=%b, required all 0",
                     if8.busy, if8.done, if8.sum, if8.cout);
        end
        checks++;
        if ({if1.busy, if1.done, if1.sum, if1.cout} !== 4'h0) begin
            errors++;
            $display("FAIL reset1 busy=%b done=%b sum=%h cout=%b, required all 0",
                     if1.busy, if1.done, if1.sum, if1.cout);
        end
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_basic();
        if8.a = 8'h5A; if8.b = 8'h33; if8.cin = 1'b0; if8.start = 1'b1;
        tick(1);
        if8.start = 1'b0;
        checks++;
        if (if8.busy !== 1'b1 || if8.done !== 1'b0) begin
            errors++;
            $display("FAIL basic_accept busy=%b done=%b, required busy=1 done=0", if8.busy, if8.done);
        end
        for (int i = 1; i < 8; i++) begin
            tick(1);
            checks++;
            if (if8.busy !== 1'b1 || if8.done !== 1'b0 || if8.sum !== 8'h00) begin
                errors++;
                $display("FAIL basic_run%0d busy=%b done=%b sum=%h, required 1 0 00",
                         i, if8.busy, if8.done, if8.sum);
            end
        end
        tick(1);
        checks++;
        if (if8.busy !== 1'b0 || if8.done !== 1'b1 || if8.sum !== 8'h8D || if8.cout !== 1'b0) begin
            errors++;
            $display("FAIL basic_done busy=%b done=%b sum=%h cout=%b, required 0 1 8d 0",
                     if8.busy, if8.done, if8.sum, if8.cout);
        end
        tick(1);
        checks++;
        if (if8.done !== 1'b0 || if8.busy !== 1'b0 || if8.sum !== 8'h8D) begin
            errors++;
            $display("FAIL basic_idle done=%b busy=%b sum=%h, required 0 0 8d", if8.done, if8.busy, if8.sum);
        end
    endtask

    task automatic test_carry();
        if8.a = 8'hFF; if8.b = 8'h01; if8.cin = 1'b0; if8.start = 1'b1;
        tick(1);
        if8.start = 1'b0;
        tick(8);
        checks++;
        if (if8.done !== 1'b1 || if8.sum !== 8'h00 || if8.cout !== 1'b1) begin
            errors++;
            $display("FAIL carry1 done=%b sum=%h cout=%b, required 1 00 1", if8.done, if8.sum, if8.cout);
        end
        tick(1);
        if8.a = 8'hFF; if8.b = 8'hFF; if8.cin = 1'b1; if8.start = 1'b1;
        tick(1);
        if8.start = 1'b0;
        for (int i = 1; i < 8; i++) begin
            tick(1);
            checks++;
            if (if8.sum !== 8'h00 || if8.cout !== 1'b1 || if8.done !== 1'b0) begin
                errors++;
                $display("FAIL carry_hold%0d sum=%h cout=%b done=%b, required 00 1 0",
                         i, if8.sum, if8.cout, if8.done);
            end
        end
        tick(1);
        checks++;
        if (if8.done !== 1'b1 || if8.sum !== 8'hFF || if8.cout !== 1'b1) begin
            errors++;
            $display("FAIL carry2 done=%b sum=%h cout=%b, required 1 ff 1", if8.done, if8.sum, if8.cout);
        end
        tick(1);
    endtask

    task automatic test_ignore_start();
        int dones;
        dones = 0;
        if8.a = 8'h10; if8.b = 8'h20; if8.cin = 1'b0; if8.start = 1'b1;
        tick(1);
        if8.a = 8'hAA; if8.b = 8'h55;
        for (int i = 1; i < 8; i++) begin
            tick(1);
            if (if8.done === 1'b1) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL ignore_early_done count=%0d, required 0", dones);
        end
        tick(1);
        checks++;
        if (if8.done !== 1'b1 || if8.sum !== 8'h30 || if8.cout !== 1'b0) begin
            errors++;
            $display("FAIL ignore_result done=%b sum=%h cout=%b, required 1 30 0", if8.done, if8.sum, if8.cout);
        end
        if8.start = 1'b0;
        tick(1);
        checks++;
        if (if8.done !== 1'b0 || if8.busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_idle done=%b busy=%b, required 0 0", if8.done, if8.busy);
        end
    endtask

    task automatic test_back_to_back();
        if8.a = 8'h01; if8.b = 8'h02; if8.cin = 1'b0; if8.start = 1'b1;
        tick(1);
        if8.a = 8'h0F; if8.b = 8'h01;
        tick(8);
        checks++;
        if (if8.done !== 1'b1 || if8.sum !== 8'h03) begin
            errors++;
            $display("FAIL b2b_first done=%b sum=%h, required 1 03", if8.done, if8.sum);
        end
        tick(1);
        checks++;
        if (if8.done !== 1'b0 || if8.busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_restart done=%b busy=%b, required 0 1", if8.done, if8.busy);
        end
        if8.start = 1'b0;
        for (int i = 1; i < 8; i++) begin
            tick(1);
            checks++;
            if (if8.done !== 1'b0 || if8.sum !== 8'h03) begin
                errors++;
                $display("FAIL b2b_run%0d done=%b sum=%h, required 0 03", i, if8.done, if8.sum);
            end
        end
        tick(1);
        checks++;
        if (if8.done !== 1'b1 || if8.sum !== 8'h10 || if8.cout !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second done=%b sum=%h cout=%b, required 1 10 0", if8.done, if8.sum, if8.cout);
        end
        tick(1);
    endtask

    task automatic test_reset_mid_run();
        int dones;
        dones = 0;
        if8.a = 8'h7F; if8.b = 8'h01; if8.cin = 1'b0; if8.start = 1'b1;
        tick(1);
        if8.start = 1'b0;
        tick(4);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({if8.busy, if8.done, if8.sum, if8.cout} !== 11'h0) begin
            errors++;
            $display("FAIL rst_mid busy=%b done=%b sum=%h cout=%b, required all 0",
                     if8.busy, if8.done, if8.sum, if8.cout);
        end
        tick(2);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (if8.done !== 1'b0 || if8.busy !== 1'b0) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL rst_no_done activity_cycles=%0d, required 0", dones);
        end
        if8.a = 8'h03; if8.b = 8'h04; if8.cin = 1'b0; if8.start = 1'b1;
        tick(1);
        if8.start = 1'b0;
        tick(8);
        checks++;
        if (if8.done !== 1'b1 || if8.sum !== 8'h07 || if8.cout !== 1'b0) begin
            errors++;
            $display("FAIL rst_after done=%b sum=%h cout=%b, required 1 07 0", if8.done, if8.sum, if8.cout);
        end
        tick(1);
    endtask

    task automatic test_width1();
        if1.a = 1'b1; if1.b = 1'b1; if1.cin = 1'b1; if1.start = 1'b1;
        tick(1);
        if1.start = 1'b0;
        checks++;
        if (if1.busy !== 1'b1 || if1.done !== 1'b0) begin
            errors++;
            $display("FAIL w1_accept busy=%b done=%b, required 1 0", if1.busy, if1.done);
        end
        tick(1);
        checks++;
        if (if1.done !== 1'b1 || if1.busy !== 1'b0 || if1.sum !== 1'b1 || if1.cout !== 1'b1) begin
            errors++;
            $display("FAIL w1_done done=%b busy=%b sum=%b cout=%b, required 1 0 1 1",
                     if1.done, if1.busy, if1.sum, if1.cout);
        end
        tick(1);
        if1.a = 1'b1; if1.b = 1'b0; if1.cin = 1'b0; if1.start = 1'b1;
        tick(1);
        if1.start = 1'b0;
        tick(1);
        checks++;
        if (if1.done !== 1'b1 || if1.sum !== 1'b1 || if1.cout !== 1'b0) begin
            errors++;
            $display("FAIL w1_second done=%b sum=%b cout=%b, required 1 1 0", if1.done, if1.sum, if1.cout);
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if (if1.done !== 1'b0 || if1.sum !== 1'b0) begin
            errors++;
            $display("FAIL w1_rst_in_done done=%b sum=%b, required 0 0", if1.done, if1.sum);
        end
        tick(1);
        rst = 1'b0;
        tick(1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        test_width1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
